// File: rtl/snake_step_sequencer_pkg.sv
// Shared encodings and defaults for the snake step sequencer: master states, directions,
// sequencer states and timing constants.
package snake_step_sequencer_pkg;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_PLAY = 2'd1,
    M_WIN  = 2'd2,
    M_LOSE = 2'd3
  } m_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_STEP,
    S_EVAL,
    S_NEW_TGT,
    S_HALT
  } seq_state_t;

  localparam int DEF_BASE_PERIOD = 10_000_000;
  localparam int DEF_MIN_PERIOD  = 2_500_000;
  localparam int DEF_SPEED_STEP  = 500_000;
  localparam int DEF_MAX_LEN     = 32;
  localparam int DEF_ACK_TIMEOUT = 1024;
  localparam int DEF_PERIOD_W    = 24;

  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_step_sequencer_step_timer.sv
// Step pacing timer: period register with clamped speed-up and an up counter whose
// expiry strobe marks the last cycle of a step interval.
module snake_step_sequencer_step_timer #(
  parameter int BASE_PERIOD = 10_000_000,
  parameter int MIN_PERIOD  = 2_500_000,
  parameter int SPEED_STEP  = 500_000,
  parameter int PERIOD_W    = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic load,
  input  logic dec,
  output logic expire
);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] count;

  function automatic logic [PERIOD_W-1:0] clamp_sub(input logic [PERIOD_W-1:0] p);
    if (p >= PERIOD_W'(MIN_PERIOD + SPEED_STEP))
      return p - PERIOD_W'(SPEED_STEP);
    return PERIOD_W'(MIN_PERIOD);
  endfunction

  assign expire = (count == period - PERIOD_W'(1));

  // Counter sits at zero whenever it is not actively timing an interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= PERIOD_W'(BASE_PERIOD);
      count  <= '0;
    end else begin
      if (load)
        period <= PERIOD_W'(BASE_PERIOD);
      else if (dec)
        period <= clamp_sub(period);
      if (run && !expire)
        count <= count + PERIOD_W'(1);
      else
        count <= '0;
    end
  end

endmodule

// File: rtl/snake_step_sequencer.sv
// Snake step sequencer: paces movement steps, filters the requested direction, evaluates
// step results and drives target regeneration, growth and scoring.
module snake_step_sequencer
  import snake_step_sequencer_pkg::*;
#(
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int SPEED_STEP  = DEF_SPEED_STEP,
  parameter int MAX_LEN     = DEF_MAX_LEN,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int PERIOD_W    = DEF_PERIOD_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] m_state,
  input  logic [1:0] dir_in,
  output logic       step_req,
  input  logic       step_ack,
  input  logic       reached,
  input  logic       hit,
  output logic [1:0] dir_out,
  output logic       grow,
  output logic       tgt_req,
  input  logic       tgt_ack,
  output logic       score_inc,
  output logic       hit_out,
  output logic [5:0] len,
  output logic       fault
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  seq_state_t      state, state_d;
  logic            step_req_d, tgt_req_d, grow_d, score_inc_d, hit_out_d, fault_d;
  logic [1:0]      dir_d;
  logic [5:0]      len_d;
  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic            reached_p0, hit_p0, reached_d, hit_d;
  logic            tick_exp, tmr_run, tmr_load, tmr_dec, reinit, play;

  function automatic logic [5:0] len_sat_inc(input logic [5:0] l);
    return (l >= 6'(MAX_LEN)) ? 6'(MAX_LEN) : l + 6'd1;
  endfunction

  assign play    = (m_state == M_PLAY);
  assign tmr_run = (state == S_WAIT_TICK) && play;

  snake_step_sequencer_step_timer #(
    .BASE_PERIOD (BASE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .SPEED_STEP  (SPEED_STEP),
    .PERIOD_W    (PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (tmr_run),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .expire (tick_exp)
  );

  always_comb begin
    state_d     = state;
    step_req_d  = step_req;
    tgt_req_d   = tgt_req;
    grow_d      = 1'b0;
    score_inc_d = 1'b0;
    hit_out_d   = hit_out;
    fault_d     = fault;
    dir_d       = dir_out;
    len_d       = len;
    to_cnt_d    = '0;
    reached_d   = reached_p0;
    hit_d       = hit_p0;
    tmr_dec     = 1'b0;
    reinit      = 1'b0;
    case (state)
      S_IDLE: begin
        if (play)
          state_d = S_WAIT_TICK;
        else if (m_state == M_IDLE)
          reinit = 1'b1;
      end
      S_WAIT_TICK: begin
        if (!play) begin
          state_d = S_IDLE;
          reinit  = (m_state == M_IDLE);
        end else if (tick_exp) begin
          state_d    = S_STEP;
          step_req_d = 1'b1;
          // A one-segment snake has no body to reverse into.
          if (!((dir_in == reverse_dir(dir_out)) && (len > 6'd1)))
            dir_d = dir_in;
        end
      end
      S_STEP: begin
        if (step_ack) begin
          step_req_d = 1'b0;
          reached_d  = reached;
          hit_d      = hit;
          state_d    = S_EVAL;
        end else if (to_cnt == TO_LAST) begin
          step_req_d = 1'b0;
          fault_d    = 1'b1;
          state_d    = S_HALT;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
        end
      end
      S_EVAL: begin
        if (hit_p0) begin
          hit_out_d = 1'b1;
          state_d   = S_HALT;
        end else if (reached_p0) begin
          grow_d      = 1'b1;
          score_inc_d = 1'b1;
          len_d       = len_sat_inc(len);
          tmr_dec     = 1'b1;
          tgt_req_d   = 1'b1;
          state_d     = S_NEW_TGT;
        end else begin
          state_d = play ? S_WAIT_TICK : S_IDLE;
        end
      end
      S_NEW_TGT: begin
        if (tgt_ack) begin
          tgt_req_d = 1'b0;
          state_d   = play ? S_WAIT_TICK : S_IDLE;
        end else if (to_cnt == TO_LAST) begin
          tgt_req_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = S_HALT;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
        end
      end
      S_HALT: begin
        if (m_state == M_IDLE) begin
          state_d   = S_IDLE;
          reinit    = 1'b1;
          hit_out_d = 1'b0;
          fault_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    tmr_load = reinit;
    if (reinit) begin
      len_d = 6'd1;
      dir_d = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      step_req   <= 1'b0;
      tgt_req    <= 1'b0;
      grow       <= 1'b0;
      score_inc  <= 1'b0;
      hit_out    <= 1'b0;
      fault      <= 1'b0;
      dir_out    <= DIR_RIGHT;
      len        <= 6'd1;
      to_cnt     <= '0;
      reached_p0 <= 1'b0;
      hit_p0     <= 1'b0;
    end else begin
      state      <= state_d;
      step_req   <= step_req_d;
      tgt_req    <= tgt_req_d;
      grow       <= grow_d;
      score_inc  <= score_inc_d;
      hit_out    <= hit_out_d;
      fault      <= fault_d;
      dir_out    <= dir_d;
      len        <= len_d;
      to_cnt     <= to_cnt_d;
      reached_p0 <= reached_d;
      hit_p0     <= hit_d;
    end
  end

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Bench for snake_step_sequencer: directed scenarios checked every cycle against a
// behavioural model, plus hand-computed latency/period/direction expectations.
module tb_snake_step_sequencer;
  import snake_step_sequencer_pkg::*;

  localparam int BASE   = 20;
  localparam int MINP   = 8;
  localparam int SPD    = 5;
  localparam int ACK_TO = 16;
  localparam int MAXL   = 32;

  localparam int MD_IDLE = 0, MD_WAIT = 1, MD_STEP = 2, MD_EVAL = 3, MD_TGT = 4, MD_HALT = 5;
  localparam logic [13:0] RST_VEC = {6'b000000, 2'b11, 6'd1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] m_state, dir_in, dir_out;
  logic       step_req, step_ack, reached, hit, grow, tgt_req, tgt_ack, score_inc, hit_out, fault;
  logic [5:0] len;

  int passed, total, n;

  logic [1:0] dir_seq [3] = '{DIR_LEFT, DIR_UP, DIR_DOWN};
  logic [1:0] dir_exp [3] = '{DIR_RIGHT, DIR_UP, DIR_UP};
  int         per_exp [3] = '{15, 10, 8};

  snake_step_sequencer #(
    .BASE_PERIOD (BASE),
    .MIN_PERIOD  (MINP),
    .SPEED_STEP  (SPD),
    .MAX_LEN     (MAXL),
    .ACK_TIMEOUT (ACK_TO),
    .PERIOD_W    (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_state   (m_state),
    .dir_in    (dir_in),
    .step_req  (step_req),
    .step_ack  (step_ack),
    .reached   (reached),
    .hit       (hit),
    .dir_out   (dir_out),
    .grow      (grow),
    .tgt_req   (tgt_req),
    .tgt_ack   (tgt_ack),
    .score_inc (score_inc),
    .hit_out   (hit_out),
    .len       (len),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Behavioural model: period and length derive from the number of targets eaten.
  int         md, left, waited, eaten;
  logic       e_sr, e_tr, e_gr, e_sc, e_hit, e_flt, p_r, p_h;
  logic [1:0] e_dir;

  function automatic int period_of(input int e);
    int p;
    p = BASE - SPD * e;
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic int len_of(input int e);
    return (1 + e > MAXL) ? MAXL : 1 + e;
  endfunction

  function automatic logic [1:0] opposite(input logic [1:0] d);
    case (d)
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      DIR_UP:    return DIR_DOWN;
      default:   return DIR_UP;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md <= MD_IDLE; eaten <= 0; left <= 0; waited <= 0;
      e_sr <= 1'b0; e_tr <= 1'b0; e_gr <= 1'b0; e_sc <= 1'b0; e_hit <= 1'b0; e_flt <= 1'b0;
      e_dir <= DIR_RIGHT; p_r <= 1'b0; p_h <= 1'b0;
    end else begin
      e_gr <= 1'b0;
      e_sc <= 1'b0;
      case (md)
        MD_IDLE:
          if (m_state == M_PLAY) begin md <= MD_WAIT; left <= period_of(eaten); end
          else if (m_state == M_IDLE) begin eaten <= 0; e_dir <= DIR_RIGHT; end
        MD_WAIT:
          if (m_state != M_PLAY) begin
            md <= MD_IDLE;
            if (m_state == M_IDLE) begin eaten <= 0; e_dir <= DIR_RIGHT; end
          end else if (left == 1) begin
            md <= MD_STEP; e_sr <= 1'b1; waited <= 0;
            if (len_of(eaten) == 1 || dir_in != opposite(e_dir)) e_dir <= dir_in;
          end else begin
            left <= left - 1;
          end
        MD_STEP:
          if (step_ack) begin e_sr <= 1'b0; p_r <= reached; p_h <= hit; md <= MD_EVAL; end
          else if (waited == ACK_TO - 1) begin e_sr <= 1'b0; e_flt <= 1'b1; md <= MD_HALT; end
          else waited <= waited + 1;
        MD_EVAL:
          if (p_h) begin e_hit <= 1'b1; md <= MD_HALT; end
          else if (p_r) begin
            e_gr <= 1'b1; e_sc <= 1'b1; eaten <= eaten + 1; e_tr <= 1'b1; waited <= 0; md <= MD_TGT;
          end else if (m_state == M_PLAY) begin md <= MD_WAIT; left <= period_of(eaten); end
          else md <= MD_IDLE;
        MD_TGT:
          if (tgt_ack) begin
            e_tr <= 1'b0;
            if (m_state == M_PLAY) begin md <= MD_WAIT; left <= period_of(eaten); end
            else md <= MD_IDLE;
          end else if (waited == ACK_TO - 1) begin e_tr <= 1'b0; e_flt <= 1'b1; md <= MD_HALT; end
          else waited <= waited + 1;
        MD_HALT:
          if (m_state == M_IDLE) begin
            md <= MD_IDLE; eaten <= 0; e_dir <= DIR_RIGHT; e_hit <= 1'b0; e_flt <= 1'b0;
          end
        default: md <= MD_IDLE;
      endcase
    end
  end

  function automatic logic [13:0] outs();
    return {step_req, tgt_req, grow, score_inc, hit_out, fault, dir_out, len};
  endfunction

  function automatic logic [13:0] model_vec();
    return {e_sr, e_tr, e_gr, e_sc, e_hit, e_flt, e_dir, 6'(len_of(eaten))};
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
  endtask

  // Every cycle advance goes through here so the model is compared on each cycle.
  task automatic tick();
    @(negedge clk);
    chk("model_cycle", int'(outs()), int'(model_vec()));
  endtask

  task automatic wait_req(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!step_req && cnt < 200);
  endtask

  task automatic pulse_step(input logic r, input logic h);
    step_ack = 1'b1; reached = r; hit = h;
    tick();
    step_ack = 1'b0; reached = 1'b0; hit = 1'b0;
  endtask

  task automatic pulse_tgt();
    tgt_ack = 1'b1;
    tick();
    tgt_ack = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0; m_state = M_IDLE; dir_in = DIR_LEFT;
    step_ack = 1'b0; reached = 1'b0; hit = 1'b0; tgt_ack = 1'b0;
    repeat (3) tick();
    chk("reset_state", int'(outs()), int'(RST_VEC));
    rst_n = 1'b1;
    tick();

    m_state = M_PLAY;
    wait_req(n);
    chk("first_latency", n, 21);
    chk("dir_len1_any", int'(dir_out), int'(DIR_LEFT));
    dir_in = DIR_RIGHT;
    pulse_step(1'b0, 1'b0);
    wait_req(n);
    chk("plain_interval", n, 21);

    for (int i = 0; i < 3; i++) begin
      pulse_step(1'b1, 1'b0);
      tick();
      chk("grow_score_pulse", int'({grow, score_inc}), int'(2'b11));
      tick();
      chk("pulse_single", int'({grow, score_inc, tgt_req}), int'(3'b001));
      pulse_tgt();
      dir_in = dir_seq[i];
      wait_req(n);
      chk("period_after_reach", n, per_exp[i]);
      chk("dir_filter", int'(dir_out), int'(dir_exp[i]));
      chk("len_grow", int'(len), i + 2);
    end

    pulse_step(1'b1, 1'b1);
    tick();
    chk("hit_priority", int'({hit_out, score_inc, grow, tgt_req}), int'(4'b1000));
    repeat (30) tick();
    chk("halt_frozen", int'({step_req, tgt_req, hit_out}), int'(3'b001));
    chk("halt_len", int'(len), 4);
    m_state = M_IDLE;
    tick();
    chk("halt_exit", int'({hit_out, len}), 1);

    m_state = M_PLAY;
    wait_req(n);
    chk("restart_latency", n, 21);
    pulse_step(1'b1, 1'b0);
    repeat (2) tick();
    pulse_tgt();
    wait_req(n);
    chk("restart_period", n, 15);
    n = 0;
    do begin
      tick();
      n++;
    end while (!fault && n < 100);
    chk("step_timeout", n, ACK_TO);
    chk("timeout_req_drop", int'(step_req), 0);
    m_state = M_IDLE;
    tick();
    chk("fault_clear", int'({fault, len}), 1);

    m_state = M_PLAY;
    wait_req(n);
    chk("third_latency", n, 21);
    pulse_step(1'b1, 1'b0);
    repeat (2) tick();
    chk("in_new_tgt", int'(tgt_req), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'(outs()), int'(RST_VEC));
    m_state = M_IDLE;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("no_tgt_after_reset", int'({tgt_req, step_req}), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
